cu_multi_cycle: RTL and testbench
=================================

Name: cu_multi_cycle

Overview:
- Multi-cycle MIPS control unit. Successor to the single-cycle combinational decoder.
- Sequences each instruction through an explicit state register: fetch, decode, execute, memory, write-back.
- Shares one ALU and one unified instruction/data memory over a req/ready handshake.
- Adds a retired-instruction counter. Sits between the instruction register (Op/Funct), ALU flags, memory port and datapath muxes.

Parameters:
- BIT_CTRL, 6, width of Op and Funct fields.
- BIT_SEL, 3, ALUControl is BIT_SEL+1 bits.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- Op  in  BIT_CTRL  opcode from IR
- Funct  in  BIT_CTRL  funct from IR
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  write qualifier for mem_req
- IorD  out  1  0=PC address, 1=ALUOut address
- IRWrite  out  1  load IR
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU Zero
- PCSource  out  2  0=ALU, 1=ALUOut, 2=jump target, 3=rs (JR)
- RegWrite  out  1  register file write
- MemtoReg  out  1  write-back from MDR
- RegDst  out  2  0=rt, 1=rd, 2=$31
- ALUSrcA  out  2  0=PC, 1=rs, 2=shamt
- ALUSrcB  out  2  0=rt, 1=const 4, 2=imm, 3=imm<<2
- ALUControl  out  BIT_SEL+1  ADD=0, OR=3, SLT=4, SLL=5, MUL=9, SUBEQ=10, SUBNE=11, PASS_A=13, LUI=14
- instr_retired  out  CNT_W  completed-instruction count
- illegal_op  out  1  trap flag (feature only; tied 0 otherwise)

Behaviour:
- Reset (synchronous on clk while rst=1):
  - State goes to FETCH; instr_retired=0; illegal_op=0.
  - While rst=1 every control output is forced 0, including mem_req.
- Outputs are decoded from state. FETCH, MEM_RD and MEM_WR additionally qualify on mem_ready.
- FETCH:
  - Drives mem_req=1, IorD=0.
  - Holds while mem_ready=0.
  - When mem_ready=1, the same cycle drives IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=1, ALUControl=ADD, PCSource=0, then moves to DECODE.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=3, ADD (branch target into ALUOut).
  - Dispatches on Op; Op=0 uses Funct.
  - Dispatch targets:
    - SLL(Funct 0), MUL(Funct 2 or Op 28) -> EXE_R.
    - JR(Funct 8) -> EXE_JR.
    - ADDI 8 / ADDIU 9 / SLTI 10 / ORI 13 / LUI 15 -> EXE_I.
    - LW 35 / SW 43 -> MEM_ADDR.
    - BEQ 4 / BNE 5 -> EXE_BR.
    - J 2 -> EXE_J; JAL 3 -> EXE_JAL.
- EXE_R:
  - SLL: ALUSrcA=2, ALUSrcB=0, ALUControl=SLL.
  - MUL: ALUSrcA=1, ALUSrcB=0, ALUControl=MUL.
  - Next state WB_R.
- WB_R: RegWrite=1, RegDst=1, MemtoReg=0; next FETCH.
- EXE_I: ALUSrcA=1, ALUSrcB=2, ALUControl per op (ADD/ADD/SLT/OR/LUI); next WB_I.
- WB_I: RegWrite=1, RegDst=0; next FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ADD; next MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_req=1, IorD=1; hold until mem_ready; then MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0; next FETCH.
- MEM_WR: mem_req=1, MemWrite=1, IorD=1; hold until mem_ready; then FETCH.
- EXE_BR: ALUSrcA=1, ALUSrcB=0, ALUControl=SUBEQ(BEQ)/SUBNE(BNE), PCWriteCond=1, PCSource=1; next FETCH.
- EXE_J: PCWrite=1, PCSource=2; next FETCH.
- EXE_JAL: PCWrite=1, PCSource=2, RegWrite=1, RegDst=2; next FETCH.
- EXE_JR: ALUSrcA=1, ALUControl=PASS_A, PCWrite=1, PCSource=3; next FETCH.
- Latency with zero-wait memory (FETCH counts 1 cycle):
  - R/I: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch/J/JAL/JR: 3 cycles.
  - Each wait cycle adds 1.
- instr_retired:
  - Increments by 1 on every transition into FETCH from a non-FETCH state (rst=0).
  - Wraps from all-ones to 0 with no flag.
- Unlisted Op/Funct: handled per the optional feature.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- rst asserted mid-instruction or mid-handshake aborts the instruction immediately; the counter is not incremented.

Optional Feature:
- CU_ILLEGAL_TRAP_EN defined:
  - Unlisted encodings go from DECODE to TRAP.
  - TRAP drives illegal_op=1 and all other controls 0.
  - Stays in TRAP until rst.
- Not defined: unlisted Op decodes as ADDI; unlisted Funct decodes as SLL; illegal_op tied 0.

Decomposition:
- Package cu_pkg holds:
  - State enum (5-bit).
  - Opcode/funct localparams.
  - ALUControl encodings.
  - ALUSrcA/ALUSrcB/PCSource/RegDst encodings.
- Sub-module cu_decode: combinational Op/Funct -> dispatch class plus ALU op. Used by the DECODE transition and the EXE_I op select.

Test Plan:
- ADDI (Op 8), mem_ready=1 constantly -> states FETCH, DECODE, EXE_I, WB_I. RegWrite=1 and RegDst=0 only in cycle 4; instr_retired 0->1.
- LW (Op 35), mem_ready low for 3 cycles in MEM_RD -> mem_req=1 and IorD=1 held 4 cycles. MemtoReg=1 and RegWrite=1 one cycle after mem_ready; total 8 cycles.
- SW (Op 43) -> MemWrite=1 only while in MEM_WR. RegWrite stays 0 throughout.
- BNE (Op 5) -> in cycle 3 PCWriteCond=1, ALUControl=11, PCSource=1, PCWrite=0.
- JAL (Op 3) then JR (Op 0, Funct 8) -> JAL drives RegDst=2, RegWrite=1, PCSource=2. JR drives PCSource=3, ALUControl=13.
- rst pulsed in MEM_RD wait -> next state FETCH with instr_retired unchanged.
- Op=63 with CU_ILLEGAL_TRAP_EN -> illegal_op=1 held. Without the macro -> ALUSrcB=2, ALUControl=0, RegWrite=1.
- Counter wrap: CNT_W=4, 16 jumps -> instr_retired returns to 0.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: state codes, opcode/funct
// values, ALU operation codes, datapath mux selects and decode dispatch classes.
package cu_pkg;

  localparam int unsigned STATE_W = 5;
  localparam int unsigned CLS_W   = 3;

  // FSM state encodings
  localparam logic [STATE_W-1:0] S_FETCH    = 5'd0;
  localparam logic [STATE_W-1:0] S_DECODE   = 5'd1;
  localparam logic [STATE_W-1:0] S_EXE_R    = 5'd2;
  localparam logic [STATE_W-1:0] S_WB_R     = 5'd3;
  localparam logic [STATE_W-1:0] S_EXE_I    = 5'd4;
  localparam logic [STATE_W-1:0] S_WB_I     = 5'd5;
  localparam logic [STATE_W-1:0] S_MEM_ADDR = 5'd6;
  localparam logic [STATE_W-1:0] S_MEM_RD   = 5'd7;
  localparam logic [STATE_W-1:0] S_MEM_WB   = 5'd8;
  localparam logic [STATE_W-1:0] S_MEM_WR   = 5'd9;
  localparam logic [STATE_W-1:0] S_EXE_BR   = 5'd10;
  localparam logic [STATE_W-1:0] S_EXE_J    = 5'd11;
  localparam logic [STATE_W-1:0] S_EXE_JAL  = 5'd12;
  localparam logic [STATE_W-1:0] S_EXE_JR   = 5'd13;
  localparam logic [STATE_W-1:0] S_TRAP     = 5'd14;

  // Opcodes and R-type funct codes
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_MUL   = 6'd28;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_MUL   = 6'd2;
  localparam logic [5:0] FN_JR    = 6'd8;

  // ALUControl encodings
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_SLT    = 4'd4;
  localparam logic [3:0] ALU_SLL    = 4'd5;
  localparam logic [3:0] ALU_MUL    = 4'd9;
  localparam logic [3:0] ALU_SUBEQ  = 4'd10;
  localparam logic [3:0] ALU_SUBNE  = 4'd11;
  localparam logic [3:0] ALU_PASS_A = 4'd13;
  localparam logic [3:0] ALU_LUI    = 4'd14;

  // Datapath mux selects
  localparam logic [1:0] SRCA_PC      = 2'd0;
  localparam logic [1:0] SRCA_RS      = 2'd1;
  localparam logic [1:0] SRCA_SHAMT   = 2'd2;
  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;
  localparam logic [1:0] REGDST_RT    = 2'd0;
  localparam logic [1:0] REGDST_RD    = 2'd1;
  localparam logic [1:0] REGDST_RA    = 2'd2;

  // Decode dispatch classes
  localparam logic [CLS_W-1:0] CLS_R   = 3'd0;
  localparam logic [CLS_W-1:0] CLS_I   = 3'd1;
  localparam logic [CLS_W-1:0] CLS_MEM = 3'd2;
  localparam logic [CLS_W-1:0] CLS_BR  = 3'd3;
  localparam logic [CLS_W-1:0] CLS_J   = 3'd4;
  localparam logic [CLS_W-1:0] CLS_JAL = 3'd5;
  localparam logic [CLS_W-1:0] CLS_JR  = 3'd6;
  localparam logic [CLS_W-1:0] CLS_ILL = 3'd7;

endpackage

// File: rtl/cu_decode.sv
// Combinational Op/Funct decode into a dispatch class, the ALU op for that class and
// a store flag. CU_ILLEGAL_TRAP_EN maps unlisted encodings to CLS_ILL.
module cu_decode
  import cu_pkg::*;
#(
  parameter int unsigned BIT_CTRL = 6,
  parameter int unsigned BIT_SEL  = 3
) (
  input  logic [BIT_CTRL-1:0] op,
  input  logic [BIT_CTRL-1:0] funct,
  output logic [CLS_W-1:0]    cls_c,
  output logic [BIT_SEL:0]    alu_op_c,
  output logic                is_store_c
);

  localparam int unsigned ALU_W = BIT_SEL + 1;

  always_comb begin
    cls_c      = CLS_I;
    alu_op_c   = ALU_W'(ALU_ADD);
    is_store_c = 1'b0;
    case (op)
      BIT_CTRL'(OP_RTYPE): begin
        case (funct)
          BIT_CTRL'(FN_SLL): begin cls_c = CLS_R;  alu_op_c = ALU_W'(ALU_SLL);    end
          BIT_CTRL'(FN_MUL): begin cls_c = CLS_R;  alu_op_c = ALU_W'(ALU_MUL);    end
          BIT_CTRL'(FN_JR):  begin cls_c = CLS_JR; alu_op_c = ALU_W'(ALU_PASS_A); end
`ifdef CU_ILLEGAL_TRAP_EN
          default:           cls_c = CLS_ILL;
`else
          default:           begin cls_c = CLS_R;  alu_op_c = ALU_W'(ALU_SLL);    end
`endif
        endcase
      end
      BIT_CTRL'(OP_MUL):   begin cls_c = CLS_R;   alu_op_c = ALU_W'(ALU_MUL);   end
      BIT_CTRL'(OP_ADDI),
      BIT_CTRL'(OP_ADDIU): begin cls_c = CLS_I;   alu_op_c = ALU_W'(ALU_ADD);   end
      BIT_CTRL'(OP_SLTI):  begin cls_c = CLS_I;   alu_op_c = ALU_W'(ALU_SLT);   end
      BIT_CTRL'(OP_ORI):   begin cls_c = CLS_I;   alu_op_c = ALU_W'(ALU_OR);    end
      BIT_CTRL'(OP_LUI):   begin cls_c = CLS_I;   alu_op_c = ALU_W'(ALU_LUI);   end
      BIT_CTRL'(OP_LW):    cls_c = CLS_MEM;
      BIT_CTRL'(OP_SW):    begin cls_c = CLS_MEM; is_store_c = 1'b1;            end
      BIT_CTRL'(OP_BEQ):   begin cls_c = CLS_BR;  alu_op_c = ALU_W'(ALU_SUBEQ); end
      BIT_CTRL'(OP_BNE):   begin cls_c = CLS_BR;  alu_op_c = ALU_W'(ALU_SUBNE); end
      BIT_CTRL'(OP_J):     cls_c = CLS_J;
      BIT_CTRL'(OP_JAL):   cls_c = CLS_JAL;
`ifdef CU_ILLEGAL_TRAP_EN
      default:             cls_c = CLS_ILL;
`else
      default:             begin cls_c = CLS_I;   alu_op_c = ALU_W'(ALU_ADD);   end
`endif
    endcase
  end

endmodule

// File: rtl/cu_multi_cycle.sv
// Multi-cycle MIPS control unit: fetch/decode/execute/memory/write-back sequencing,
// memory req/ready handshake and a retired-instruction counter. CU_ILLEGAL_TRAP_EN adds TRAP.
module cu_multi_cycle
  import cu_pkg::*;
#(
  parameter int unsigned BIT_CTRL = 6,
  parameter int unsigned BIT_SEL  = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BIT_CTRL-1:0] Op,
  input  logic [BIT_CTRL-1:0] Funct,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                MemWrite,
  output logic                IorD,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic [1:0]          PCSource,
  output logic                RegWrite,
  output logic                MemtoReg,
  output logic [1:0]          RegDst,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [BIT_SEL:0]    ALUControl,
  output logic [CNT_W-1:0]    instr_retired,
  output logic                illegal_op
);

  localparam int unsigned ALU_W = BIT_SEL + 1;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic [CLS_W-1:0]   cls_c;
  logic [ALU_W-1:0]   alu_op_c;
  logic               is_store_c;

  cu_decode #(
    .BIT_CTRL (BIT_CTRL),
    .BIT_SEL  (BIT_SEL)
  ) u_decode (
    .op         (Op),
    .funct      (Funct),
    .cls_c      (cls_c),
    .alu_op_c   (alu_op_c),
    .is_store_c (is_store_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next state and state-decoded controls; everything stays 0 while rst is high
  always_comb begin
    state_d     = state_q;
    retired_d   = retired_q;
    mem_req     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = PCSRC_ALU;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = REGDST_RT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RT;
    ALUControl  = ALU_W'(ALU_ADD);
    illegal_op  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            ALUSrcA    = SRCA_PC;
            ALUSrcB    = SRCB_FOUR;
            ALUControl = ALU_W'(ALU_ADD);
            PCSource   = PCSRC_ALU;
            state_d    = S_DECODE;
          end
        end
        S_DECODE: begin
          // Branch target is computed speculatively into ALUOut
          ALUSrcA    = SRCA_PC;
          ALUSrcB    = SRCB_IMM_SL2;
          ALUControl = ALU_W'(ALU_ADD);
          case (cls_c)
            CLS_R:   state_d = S_EXE_R;
            CLS_I:   state_d = S_EXE_I;
            CLS_MEM: state_d = S_MEM_ADDR;
            CLS_BR:  state_d = S_EXE_BR;
            CLS_J:   state_d = S_EXE_J;
            CLS_JAL: state_d = S_EXE_JAL;
            CLS_JR:  state_d = S_EXE_JR;
`ifdef CU_ILLEGAL_TRAP_EN
            default: state_d = S_TRAP;
`else
            default: state_d = S_EXE_I;
`endif
          endcase
        end
        S_EXE_R: begin
          ALUSrcA    = (alu_op_c == ALU_W'(ALU_SLL)) ? SRCA_SHAMT : SRCA_RS;
          ALUSrcB    = SRCB_RT;
          ALUControl = alu_op_c;
          state_d    = S_WB_R;
        end
        S_WB_R: begin
          RegWrite = 1'b1;
          RegDst   = REGDST_RD;
          state_d  = S_FETCH;
        end
        S_EXE_I: begin
          ALUSrcA    = SRCA_RS;
          ALUSrcB    = SRCB_IMM;
          ALUControl = alu_op_c;
          state_d    = S_WB_I;
        end
        S_WB_I: begin
          RegWrite = 1'b1;
          RegDst   = REGDST_RT;
          state_d  = S_FETCH;
        end
        S_MEM_ADDR: begin
          ALUSrcA    = SRCA_RS;
          ALUSrcB    = SRCB_IMM;
          ALUControl = ALU_W'(ALU_ADD);
          state_d    = is_store_c ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          IorD    = 1'b1;
          if (mem_ready) state_d = S_MEM_WB;
        end
        S_MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
          RegDst   = REGDST_RT;
          state_d  = S_FETCH;
        end
        S_MEM_WR: begin
          mem_req  = 1'b1;
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (mem_ready) state_d = S_FETCH;
        end
        S_EXE_BR: begin
          ALUSrcA     = SRCA_RS;
          ALUSrcB     = SRCB_RT;
          ALUControl  = alu_op_c;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          state_d     = S_FETCH;
        end
        S_EXE_J: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
          state_d  = S_FETCH;
        end
        S_EXE_JAL: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
          RegWrite = 1'b1;
          RegDst   = REGDST_RA;
          state_d  = S_FETCH;
        end
        S_EXE_JR: begin
          ALUSrcA    = SRCA_RS;
          ALUControl = ALU_W'(ALU_PASS_A);
          PCWrite    = 1'b1;
          PCSource   = PCSRC_RS;
          state_d    = S_FETCH;
        end
`ifdef CU_ILLEGAL_TRAP_EN
        S_TRAP: illegal_op = 1'b1;
`endif
        default: state_d = S_FETCH;
      endcase
      // Count each completed instruction as it hands control back to FETCH
      if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
        retired_d = retired_q + CNT_W'(1);
      end
    end
  end

  assign instr_retired = retired_q;

endmodule

// File: tb/tb_cu_multi_cycle.sv
// Directed testbench for cu_multi_cycle: per-cycle control words for each instruction
// class, memory wait states, mid-instruction reset and retired-counter wrap.
module tb_cu_multi_cycle;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op, Funct;
  logic       mem_ready;

  logic        mem_req, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, RegWrite, MemtoReg;
  logic [1:0]  PCSource, RegDst, ALUSrcA, ALUSrcB;
  logic [3:0]  ALUControl;
  logic [15:0] instr_retired;
  logic        illegal_op;

  logic        w4_mem_req, w4_MemWrite, w4_IorD, w4_IRWrite, w4_PCWrite, w4_PCWriteCond;
  logic        w4_RegWrite, w4_MemtoReg, w4_illegal_op;
  logic [1:0]  w4_PCSource, w4_RegDst, w4_ALUSrcA, w4_ALUSrcB;
  logic [3:0]  w4_ALUControl;
  logic [3:0]  w4_instr_retired;

  int n_tests = 0;
  int n_fail  = 0;

  logic [20:0] ctrl;
  logic [20:0] w_frdy, w_fwait, w_dec, w_exi_add, w_exi_or, w_wbi, w_mrd, w_mwb, w_mwr;
  logic [20:0] w_bne, w_j, w_jal, w_jr, w_exr_mul, w_exr_sll, w_wbr, w_zero;

  always #5 clk = ~clk;

  cu_multi_cycle dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .instr_retired(instr_retired),
    .illegal_op(illegal_op)
  );

  cu_multi_cycle #(.CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
    .mem_req(w4_mem_req), .MemWrite(w4_MemWrite), .IorD(w4_IorD), .IRWrite(w4_IRWrite),
    .PCWrite(w4_PCWrite), .PCWriteCond(w4_PCWriteCond), .PCSource(w4_PCSource),
    .RegWrite(w4_RegWrite), .MemtoReg(w4_MemtoReg), .RegDst(w4_RegDst),
    .ALUSrcA(w4_ALUSrcA), .ALUSrcB(w4_ALUSrcB), .ALUControl(w4_ALUControl),
    .instr_retired(w4_instr_retired), .illegal_op(w4_illegal_op)
  );

  assign ctrl = {mem_req, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource,
                 RegWrite, MemtoReg, RegDst, ALUSrcA, ALUSrcB, ALUControl, illegal_op};

  function automatic logic [20:0] cw(input int mr, input int mw, input int iord, input int irw,
                                     input int pcw, input int pcc, input int pcs, input int rw,
                                     input int m2r, input int rd, input int sa, input int sb,
                                     input int alu, input int ill);
    return {1'(mr), 1'(mw), 1'(iord), 1'(irw), 1'(pcw), 1'(pcc), 2'(pcs), 1'(rw), 1'(m2r),
            2'(rd), 2'(sa), 2'(sb), 4'(alu), 1'(ill)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Check the control word for the current cycle, then advance one clock
  task automatic step(input string tag, input logic [20:0] exp);
    #1;
    check(tag, 32'(ctrl), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            mr mw io ir pw pc ps rw mr rd sa sb alu ill
    w_frdy    = cw(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0,  0);
    w_fwait   = cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0);
    w_dec     = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0,  0);
    w_exi_add = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0,  0);
    w_exi_or  = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3,  0);
    w_wbi     = cw(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0);
    w_mrd     = cw(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0);
    w_mwb     = cw(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,  0);
    w_mwr     = cw(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0);
    w_bne     = cw(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 11, 0);
    w_j       = cw(0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0,  0);
    w_jal     = cw(0, 0, 0, 0, 1, 0, 2, 1, 0, 2, 0, 0, 0,  0);
    w_jr      = cw(0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 1, 0, 13, 0);
    w_exr_mul = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 9,  0);
    w_exr_sll = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 5,  0);
    w_wbr     = cw(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0,  0);
    w_zero    = '0;

    rst = 1'b1; mem_ready = 1'b1; Op = 6'd0; Funct = 6'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_ctrl", 32'(ctrl), 32'(w_zero));
    check("rst_cnt", 32'(instr_retired), 32'd0);
    rst = 1'b0;

    // LW aborted by reset while waiting in MEM_RD
    Op = 6'd35;
    step("ab_f", w_frdy); step("ab_d", w_dec); step("ab_ma", w_exi_add);
    mem_ready = 1'b0;
    step("ab_rd", w_mrd);
    rst = 1'b1;
    step("ab_rst", w_zero);
    rst = 1'b0;
    check("ab_cnt", 32'(instr_retired), 32'd0);
    step("ab_fwait", w_fwait);
    mem_ready = 1'b1;

    // ADDI: 4 cycles
    Op = 6'd8;
    step("addi_f", w_frdy); step("addi_d", w_dec); step("addi_x", w_exi_add);
    check("addi_cnt0", 32'(instr_retired), 32'd0);
    step("addi_wb", w_wbi);
    check("addi_cnt1", 32'(instr_retired), 32'd1);

    // LW with 3 wait cycles in MEM_RD: 8 cycles
    Op = 6'd35;
    step("lw_f", w_frdy); step("lw_d", w_dec); step("lw_ma", w_exi_add);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step($sformatf("lw_wait%0d", i), w_mrd);
    mem_ready = 1'b1;
    step("lw_rd", w_mrd); step("lw_wb", w_mwb);
    check("lw_cnt", 32'(instr_retired), 32'd2);

    // SW: 4 cycles
    Op = 6'd43;
    step("sw_f", w_frdy); step("sw_d", w_dec); step("sw_ma", w_exi_add); step("sw_wr", w_mwr);
    check("sw_cnt", 32'(instr_retired), 32'd3);

    // BNE, with mem_ready low outside memory states
    Op = 6'd5;
    step("bne_f", w_frdy);
    mem_ready = 1'b0;
    step("bne_d", w_dec); step("bne_x", w_bne);
    mem_ready = 1'b1;
    check("bne_cnt", 32'(instr_retired), 32'd4);

    // JAL then JR
    Op = 6'd3;
    step("jal_f", w_frdy); step("jal_d", w_dec); step("jal_x", w_jal);
    Op = 6'd0; Funct = 6'd8;
    step("jr_f", w_frdy); step("jr_d", w_dec); step("jr_x", w_jr);
    check("jr_cnt", 32'(instr_retired), 32'd6);

    // MUL via Op 28, then SLL with one fetch wait cycle
    Op = 6'd28; Funct = 6'd0;
    step("mul_f", w_frdy); step("mul_d", w_dec); step("mul_x", w_exr_mul); step("mul_wb", w_wbr);
    Op = 6'd0; Funct = 6'd0; mem_ready = 1'b0;
    step("sll_fwait", w_fwait);
    mem_ready = 1'b1;
    step("sll_f", w_frdy); step("sll_d", w_dec); step("sll_x", w_exr_sll); step("sll_wb", w_wbr);
    check("sll_cnt", 32'(instr_retired), 32'd8);

    // ORI
    Op = 6'd13;
    step("ori_f", w_frdy); step("ori_d", w_dec); step("ori_x", w_exi_or); step("ori_wb", w_wbi);
    check("ori_cnt", 32'(instr_retired), 32'd9);

    // Unlisted opcode 63
    Op = 6'd63;
    step("ill_f", w_frdy); step("ill_d", w_dec);
`ifdef CU_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) step($sformatf("ill_trap%0d", i), cw(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
    check("ill_cnt", 32'(instr_retired), 32'd9);
`else
    step("ill_x", w_exi_add); step("ill_wb", w_wbi);
    check("ill_cnt", 32'(instr_retired), 32'd10);
`endif

    // Counter wrap on the 4-bit instance: 16 jumps from reset
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("wrap_rst", 32'(w4_instr_retired), 32'd0);
    Op = 6'd2;
    for (int i = 0; i < 16; i++) begin
      step($sformatf("j%0d_f", i), w_frdy);
      step($sformatf("j%0d_d", i), w_dec);
      step($sformatf("j%0d_x", i), w_j);
      if (i == 14) check("wrap_15", 32'(w4_instr_retired), 32'd15);
    end
    check("wrap_0", 32'(w4_instr_retired), 32'd0);
    check("cnt_16", 32'(instr_retired), 32'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
